// File: rtl/ddr_pix_wr.sv
// ddr_pix_wr
//   Packs a 24-bit RGB pixel stream into 240-bit frame-buffer words (10 pixels,
//   first pixel in [239:216]) and issues one single-beat DDR write per word.
//   Words are addressed with a 32-byte stride and wrap to 0 after MAX_ADDR.
//
// Ports
//   ddr_clk     : single clock
//   rst         : synchronous reset, active-high
//   init_done   : DDR calibrated; no new pixel or write activity while low
//   pix_valid   : pixel offered            pix_ready : pixel accepted when both high
//   pix_data    : {R,G,B}                  pix_sof   : transferred pixel starts a frame
//   wr_req      : write request, held until wr_ack
//   ddr_wr_adr  : write address            awlen     : burst length - 1 (always 0)
//   ddr_wdata   : write data, [255:240]=0  wr_ack    : one-cycle ack, consumes request
//   sof_err     : one-cycle pulse, frame start arrived with a partial word pending
module ddr_pix_wr #(
    parameter int                PIX_W        = 24,
    parameter int                PIX_PER_WORD = 10,
    parameter int                ADDR_W       = 28,
    parameter int                DATA_W       = 256,
    parameter int                ADDR_STEP    = 32,
    parameter logic [ADDR_W-1:0] MAX_ADDR     = 28'h0653FE0
) (
    input  logic              ddr_clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_sof,
    output logic              wr_req,
    output logic [ADDR_W-1:0] ddr_wr_adr,
    output logic [3:0]        awlen,
    output logic [DATA_W-1:0] ddr_wdata,
    input  logic              wr_ack,
    output logic              sof_err
);

    localparam int PIX_BITS = PIX_W * PIX_PER_WORD;
    localparam int SLOT_W   = $clog2(PIX_PER_WORD);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PIX_PER_WORD - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_POP} state_t;

    state_t state, state_nxt;

    // Ascending packed range puts slot 0 in the most significant pixel position.
    logic [0:PIX_PER_WORD-1][PIX_W-1:0] word_buf, word_nxt;

    logic [SLOT_W-1:0] slot, slot_eff;
    logic [ADDR_W-1:0] next_adr, adr_eff;
    logic              xfer, push, pop;

    logic [PIX_BITS-1:0] q_data [2];
    logic [ADDR_W-1:0]   q_adr  [2];
    logic                wr_ptr, rd_ptr;
    logic [1:0]          q_cnt, q_cnt_nxt;

    // ------------------------------------------------------------------
    // Packer
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        xfer     = pix_valid & pix_ready;
        // A frame start restarts both the slot and the frame address.
        slot_eff = pix_sof ? '0 : slot;
        adr_eff  = pix_sof ? '0 : next_adr;
        word_nxt = word_buf;
        word_nxt[slot_eff] = pix_data;
        push     = xfer && (slot_eff == LAST_SLOT);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ddr_clk) begin
        if (rst) begin
            slot     <= '0;
            next_adr <= '0;
            sof_err  <= 1'b0;
        end else begin
            sof_err <= xfer & pix_sof & (slot != '0);
            if (xfer) begin
                if (push) begin
                    slot     <= '0;
                    next_adr <= (adr_eff == MAX_ADDR) ? '0 : adr_eff + ADDR_W'(ADDR_STEP);
                end else begin
                    slot     <= slot_eff + 1'b1;
                    next_adr <= adr_eff;
                end
            end
        end
    end

    // NOTE: pure data storage carries no reset; it is only observed once qualified by valid state.
    always_ff @(posedge ddr_clk) begin
        if (xfer) word_buf <= word_nxt;
        if (push) begin
            q_data[wr_ptr] <= word_nxt;
            q_adr[wr_ptr]  <= adr_eff;
        end
    end

    // ------------------------------------------------------------------
    // Two-entry word queue; the head stays in place while it is being written
    // ------------------------------------------------------------------
    always_comb begin
        q_cnt_nxt = q_cnt;
        if (push && !pop)      q_cnt_nxt = q_cnt + 2'd1;
        else if (pop && !push) q_cnt_nxt = q_cnt - 2'd1;
    end

    always_ff @(posedge ddr_clk) begin
        if (rst) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            q_cnt     <= 2'd0;
            pix_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            q_cnt     <= q_cnt_nxt;
            // Looks one cycle ahead so a full queue never accepts a tenth pixel.
            pix_ready <= init_done && (q_cnt_nxt < 2'd2);
        end
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_ff @(posedge ddr_clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (q_cnt != 2'd0 && init_done) state_nxt = S_REQ;
            S_REQ:   if (wr_ack) state_nxt = S_POP;
            S_POP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        wr_req     = (state == S_REQ);
        pop        = (state == S_POP);
        ddr_wr_adr = '0;
        ddr_wdata  = '0;
        if (wr_req) begin
            ddr_wr_adr = q_adr[rd_ptr];
            ddr_wdata  = {{(DATA_W - PIX_BITS){1'b0}}, q_data[rd_ptr]};
        end
    end

    assign awlen = 4'd0;

endmodule
